// File: rtl/mem_stage_pkg.sv
// Shared core types for the memory stage: pipeline bundles, result-source and access-size codes.
package mem_stage_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [1:0]  resultsrc;
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [31:0] pcplus4;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memwrite;
  } ex_mem_t;

  typedef struct packed {
    logic [1:0]  resultsrc;
    logic [31:0] aluresult;
    logic [31:0] pcplus4;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        regwrite;
  } mem_wb_t;

  function automatic mem_wb_t to_mem_wb(ex_mem_t e);
    mem_wb_t w;
    w.resultsrc = e.resultsrc;
    w.aluresult = e.aluresult;
    w.pcplus4   = e.pcplus4;
    w.funct3    = e.funct3;
    w.rd        = e.rd;
    w.regwrite  = e.regwrite;
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Lane logic for data-memory accesses: byte enables, store lane shift, load right-align, misalign check.
module mem_stage_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rd_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      SZ_BYTE: be_o = 4'b0001 << off_i;
      SZ_HALF: begin
        be_o       = 4'b0011 << off_i;
        misalign_o = off_i[0];
      end
      SZ_WORD: begin
        be_o       = 4'b1111;
        misalign_o = |off_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

  // Load offset comes from the captured request, not the live address.
  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign rdata_o = rdata_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on the dmem handshake and registers the
// writeback bundle with right-aligned load data.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | accepting instructions; drives the request for aligned memory ops
// S_WAIT_RESP | load accepted by the bus, waiting for dmem_rvalid
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_t     in,
  input  logic        in_valid,
  output logic        stall,
  output logic        misalign,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output mem_wb_t     out,
  output logic [31:0] out_readdata,
  output logic        out_valid
);

  typedef enum logic {S_IDLE, S_WAIT_RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  mem_wb_t     out_q, out_d;
  logic [31:0] rdd_q, rdd_d;
  logic        ov_q, ov_d;

  logic        mem_op;
  logic        bad_align;
  logic [31:0] ld_aligned;

  mem_stage_lsu_align u_align (
    .funct3_i   (in.funct3),
    .off_i      (in.aluresult[1:0]),
    .wdata_i    (in.writedata),
    .rd_off_i   (off_q),
    .rdata_i    (dmem_rdata),
    .be_o       (dmem_be),
    .wdata_o    (dmem_wdata),
    .rdata_o    (ld_aligned),
    .misalign_o (bad_align)
  );

  assign mem_op    = in_valid && (in.memwrite || (in.resultsrc == RES_MEM));
  assign dmem_we   = in.memwrite;
  assign dmem_addr = {in.aluresult[31:2], 2'b00};

  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    // Default is a bubble: anything that stalls or drops the access lands here.
    out_d           = to_mem_wb(in);
    out_d.regwrite  = 1'b0;
    ov_d            = 1'b0;
    rdd_d           = '0;
    stall           = 1'b0;
    misalign        = 1'b0;
    dmem_req        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!mem_op) begin
          out_d = to_mem_wb(in);
          ov_d  = in_valid;
        end else if (bad_align) begin
          misalign = 1'b1;
          ov_d     = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ready && in.memwrite) begin
            out_d = to_mem_wb(in);
            ov_d  = 1'b1;
          end else begin
            stall = 1'b1;
            if (dmem_ready) begin
              state_d = S_WAIT_RESP;
              off_d   = in.aluresult[1:0];
            end
          end
        end
      end
      S_WAIT_RESP: begin
        if (dmem_rvalid) begin
          out_d   = to_mem_wb(in);
          ov_d    = 1'b1;
          rdd_d   = ld_aligned;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      out_q   <= '0;
      rdd_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      out_q   <= out_d;
      rdd_q   <= rdd_d;
      ov_q    <= ov_d;
    end
  end

  assign out          = out_q;
  assign out_readdata = rdd_q;
  assign out_valid    = ov_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of the stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  ex_mem_t     in;
  logic        in_valid;
  logic        stall, misalign, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, out_readdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid, out_valid;
  mem_wb_t     out;

  mem_stage dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .stall(stall), .misalign(misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .out(out), .out_readdata(out_readdata), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // expectations for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_mis, exp_ov;
  logic [31:0] exp_addr, exp_wdata, exp_rdd;
  logic [3:0]  exp_be;
  mem_wb_t     exp_out;
  int          reg_mode;   // 0 none, 1 bubble, 2 full result
  // expectation for registered outputs after the coming edge
  int          nxt_mode;
  mem_wb_t     nxt_out;
  logic        nxt_ov;
  logic [31:0] nxt_rdd;

  logic [3:0]  snap_be;
  logic [31:0] snap_wdata, snap_addr, snap_rdd;
  logic        snap_req, snap_mis, snap_ov;
  mem_wb_t     snap_out;
  int          snap_stalls;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 96'(stall), 96'(exp_stall));
      chk("dmem_req", 96'(dmem_req), 96'(exp_req));
      chk("misalign", 96'(misalign), 96'(exp_mis));
      if (exp_req) begin
        chk("dmem_we", 96'(dmem_we), 96'(exp_we));
        chk("dmem_addr", 96'(dmem_addr), 96'(exp_addr));
        chk("dmem_be", 96'(dmem_be), 96'(exp_be));
        chk("dmem_wdata", 96'(dmem_wdata), 96'(exp_wdata));
      end
      if (reg_mode == 1) begin
        chk("bubble_valid", 96'(out_valid), 96'(1'b0));
        chk("bubble_regwrite", 96'(out.regwrite), 96'(1'b0));
      end else if (reg_mode == 2) begin
        chk("out_valid", 96'(out_valid), 96'(exp_ov));
        chk("out", 96'(out), 96'(exp_out));
        chk("out_readdata", 96'(out_readdata), 96'(exp_rdd));
      end
    end
  end

  function automatic mem_wb_t model_wb(ex_mem_t e, logic clr_rw);
    mem_wb_t w;
    w.resultsrc = e.resultsrc;
    w.aluresult = e.aluresult;
    w.pcplus4   = e.pcplus4;
    w.funct3    = e.funct3;
    w.rd        = e.rd;
    w.regwrite  = clr_rw ? 1'b0 : e.regwrite;
    return w;
  endfunction

  // Runs one instruction: R cycles before ready, response V cycles after acceptance.
  task automatic run_instr(input ex_mem_t e, input logic v, input int R, input int V,
                           input logic stray, input logic use_fixed, input logic [31:0] fixed_rd);
    logic        mem, mis, st, ld;
    int          sz, off, T;
    logic [31:0] rd_at;
    mem   = v && (e.memwrite || e.resultsrc == 2'b01);
    st    = mem && e.memwrite;
    ld    = mem && !e.memwrite;
    off   = int'(e.aluresult[1:0]);
    sz    = 1 << e.funct3[1:0];
    mis   = mem && ((e.funct3[1:0] == 2'b11) || (off % sz) != 0);
    T     = (!mem || mis) ? 1 : (st ? R + 1 : R + V + 1);
    rd_at = '0;
    snap_stalls = 0;
    for (int k = 0; k < T; k++) begin
      @(posedge clk);
      #1;
      reg_mode = nxt_mode;
      exp_out  = nxt_out;
      exp_ov   = nxt_ov;
      exp_rdd  = nxt_rdd;
      in         = e;
      in_valid   = v;
      dmem_rdata = use_fixed ? fixed_rd : $urandom;
      if (mem && !mis) dmem_ready = (k == R);
      else dmem_ready = 1'($urandom_range(0, 1));
      if (ld && !mis) dmem_rvalid = (k == R + V) || (stray && k < R);
      else dmem_rvalid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ld && !mis && k == R + V) rd_at = dmem_rdata;
      exp_stall = (k < T - 1);
      exp_req   = mem && !mis && (k <= R);
      exp_we    = st;
      exp_addr  = e.aluresult & 32'hFFFF_FFFC;
      exp_be    = 4'(((1 << sz) - 1) << off);
      exp_wdata = e.writedata << (8 * off);
      exp_mis   = mis;
      chk_en    = 1'b1;
      #1;
      if (k == 0) begin
        snap_be = dmem_be; snap_wdata = dmem_wdata; snap_addr = dmem_addr;
        snap_req = dmem_req; snap_mis = misalign;
        snap_out = out; snap_ov = out_valid; snap_rdd = out_readdata;
      end
      if (stall) snap_stalls++;
      nxt_mode = (k < T - 1) ? 1 : 2;
    end
    nxt_out = model_wb(e, mis);
    nxt_ov  = mem ? 1'b1 : v;
    nxt_rdd = (ld && !mis) ? (rd_at >> (8 * off)) : 32'h0;
  endtask

  function automatic ex_mem_t mk(logic [1:0] rs, logic [31:0] a, logic [31:0] wd, logic [2:0] f3,
                                 logic rw, logic mw);
    ex_mem_t e;
    e.resultsrc = rs; e.aluresult = a; e.writedata = wd; e.pcplus4 = $urandom;
    e.funct3 = f3; e.rd = 5'($urandom_range(0, 31)); e.regwrite = rw; e.memwrite = mw;
    return e;
  endfunction

  ex_mem_t e, idle_e;

  initial begin
    rst = 1'b1; in = '0; in_valid = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    idle_e = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 96'(out_valid), 96'(1'b0));
    chk("rst_out", 96'(out), 96'(0));
    chk("rst_readdata", 96'(out_readdata), 96'(0));
    chk("rst_stall", 96'(stall), 96'(1'b0));
    chk("rst_req", 96'(dmem_req), 96'(1'b0));
    chk("rst_misalign", 96'(misalign), 96'(1'b0));
    rst = 1'b0;
    nxt_mode = 2; nxt_out = '0; nxt_ov = 1'b0; nxt_rdd = '0;

    // ALU op
    run_instr(mk(2'b00, 32'h1234, 32'h0, 3'b000, 1'b1, 1'b0), 1'b1, 0, 1, 1'b0, 1'b0, 32'h0);
    chk("alu_req", 96'(snap_req), 96'(1'b0));
    chk("alu_stalls", 96'(snap_stalls), 96'(0));
    // sb at 0x103
    run_instr(mk(2'b00, 32'h103, 32'hAB, 3'b000, 1'b0, 1'b1), 1'b1, 0, 1, 1'b0, 1'b0, 32'h0);
    chk("alu_out_addr", 96'(snap_out.aluresult), 96'(32'h1234));
    chk("alu_out_valid", 96'(snap_ov), 96'(1'b1));
    chk("sb_be", 96'(snap_be), 96'(4'b1000));
    chk("sb_wdata", 96'(snap_wdata), 96'(32'hAB00_0000));
    chk("sb_addr", 96'(snap_addr), 96'(32'h100));
    chk("sb_stalls", 96'(snap_stalls), 96'(0));
    // lh at 0x202
    run_instr(mk(2'b01, 32'h202, 32'h0, 3'b001, 1'b1, 1'b0), 1'b1, 0, 1, 1'b0, 1'b1, 32'h8001_0000);
    chk("lh_stalls", 96'(snap_stalls), 96'(1));
    // lw with ready low for 3 cycles
    run_instr(mk(2'b01, 32'h400, 32'h0, 3'b010, 1'b1, 1'b0), 1'b1, 3, 1, 1'b0, 1'b0, 32'h0);
    chk("lh_readdata", 96'(snap_rdd), 96'(32'h8001));
    chk("lw_wait_stalls", 96'(snap_stalls), 96'(4));
    // lw at 0x102 is dropped
    run_instr(mk(2'b01, 32'h102, 32'h0, 3'b010, 1'b1, 1'b0), 1'b1, 0, 1, 1'b0, 1'b0, 32'h0);
    chk("mis_pulse", 96'(snap_mis), 96'(1'b1));
    chk("mis_req", 96'(snap_req), 96'(1'b0));
    run_instr(idle_e, 1'b0, 0, 1, 1'b0, 1'b0, 32'h0);
    chk("mis_regwrite", 96'(snap_out.regwrite), 96'(1'b0));
    chk("mis_valid", 96'(snap_ov), 96'(1'b1));

    // reset while waiting for a load response, then a stray rvalid
    e = mk(2'b01, 32'h300, 32'h0, 3'b010, 1'b1, 1'b0);
    @(posedge clk); #1;
    reg_mode = nxt_mode; exp_out = nxt_out; exp_ov = nxt_ov; exp_rdd = nxt_rdd;
    in = e; in_valid = 1'b1; dmem_ready = 1'b1; dmem_rvalid = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h300;
    exp_be = 4'b1111; exp_wdata = e.writedata; exp_mis = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;
    dmem_ready = 1'b0;
    chk("wait_stall", 96'(stall), 96'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; dmem_rvalid = 1'b1;
    #1;
    chk("rst_wait_stall", 96'(stall), 96'(1'b0));
    chk("rst_wait_req", 96'(dmem_req), 96'(1'b0));
    chk("rst_wait_valid", 96'(out_valid), 96'(1'b0));
    chk("rst_wait_out", 96'(out), 96'(0));
    nxt_mode = 2; nxt_out = model_wb(e, 1'b0); nxt_ov = 1'b0; nxt_rdd = '0;

    for (int n = 0; n < 300; n++) begin
      int kind, f3sz;
      logic [31:0] a;
      logic [1:0]  rs;
      logic        mw;
      kind = $urandom_range(0, 3);
      a    = $urandom;
      f3sz = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & 2'(~((1 << (f3sz % 4)) - 1));
      case (kind)
        0:       begin rs = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00; mw = 1'b0; end
        1:       begin rs = 2'b01; mw = 1'b0; end
        2:       begin rs = 2'(($urandom_range(0, 1)) * 2); mw = 1'b1; end
        default: begin rs = 2'($urandom_range(0, 3)); mw = 1'($urandom_range(0, 1)); end
      endcase
      run_instr(mk(rs, a, $urandom, 3'(f3sz), 1'($urandom_range(0, 1)), mw),
                1'($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(1, 3),
                1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end
    run_instr(idle_e, 1'b0, 0, 1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
